// File: rtl/i281_pkg.sv
// Shared definitions for the i281 fetch/execute sequencer: sequencer states,
// code memory geometry and instruction field positions.
package i281_pkg;

  localparam int ADDR_W      = 6;
  localparam int INSTR_W     = 17;
  localparam int MC_FLAG_BIT = 16;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_EXEC2  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  localparam logic [1:0] PHASE_NONE  = 2'd0;
  localparam logic [1:0] PHASE_EXEC1 = 2'd1;
  localparam logic [1:0] PHASE_EXEC2 = 2'd2;

endpackage

// File: rtl/pc_next_calc.sv
// Next program counter: pc+1, plus the sign-extended immediate when the
// branch is taken, wrapping modulo the code memory size.
module pc_next_calc #(
  parameter int ADDR_W = 6,
  parameter int IMM_W  = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc_next
);

  localparam int EXT_W = (ADDR_W > IMM_W) ? ADDR_W : IMM_W;

  logic [EXT_W-1:0] imm_ext;

  always_comb begin
    imm_ext = EXT_W'($signed(imm));
    // Sum at the wider width, then truncate: the wrap is the mod-2^ADDR_W result.
    pc_next = ADDR_W'(EXT_W'(pc) + EXT_W'(1) + (branch_taken ? imm_ext : EXT_W'(0)));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch/execute sequencer for the i281 multicycle CPU.
// Drives the code memory address and presents a stable instruction/phase to the decoder.
//
// state   | meaning
// FETCH   | pc on read_select; code memory samples it at the closing edge
// EXEC1   | instruction passes straight through from the code memory
// EXEC2   | extra execute cycle for flagged instructions; instruction from ir
// HALTED  | stopped until reset
module fetch_sequencer #(
  parameter int ADDR_W   = i281_pkg::ADDR_W,
  parameter int INSTR_W  = i281_pkg::INSTR_W,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] curr_instruction,
  input  logic               multicycle_flag,
  input  logic               branch_taken,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  read_select,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [1:0]         exec_phase,
  output logic               last_phase,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count
);

  import i281_pkg::*;

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_target;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_last;

  assign read_select   = pc_q;
  assign retired_count = cnt_q;
  assign halted        = (state_q == ST_HALTED);
  assign instr         = (state_q == ST_EXEC1) ? curr_instruction : ir_q;

  pc_next_calc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_pc_next (
    .pc           (pc_q),
    .imm          (instr[IMM_LSB +: IMM_W]),
    .branch_taken (branch_taken),
    .pc_next      (pc_target)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    is_last    = 1'b0;
    exec_phase = PHASE_NONE;

    case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        exec_phase = PHASE_EXEC1;
        is_last    = !multicycle_flag;
        if (run) begin
          ir_d = curr_instruction;
          if (multicycle_flag) state_d = ST_EXEC2;
        end
      end
      ST_EXEC2: begin
        exec_phase = PHASE_EXEC2;
        is_last    = 1'b1;
      end
      ST_HALTED: ;
      default: state_d = ST_FETCH;
    endcase

    // Retire; halt wins over branch and leaves pc on the halting instruction.
    if (run && is_last) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (halt_req) begin
        state_d = ST_HALTED;
      end else begin
        pc_d    = pc_target;
        state_d = ST_FETCH;
      end
    end

    instr_valid = run && (exec_phase != PHASE_NONE);
    last_phase  = run && is_last;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vectors, corner sequences
// and a randomized run against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halt_req = 1'b0;
  logic        multicycle_flag = 1'b0;
  logic [16:0] curr_instruction = '0;
  logic [5:0]  read_select;
  logic [16:0] instr;
  logic        instr_valid;
  logic [1:0]  exec_phase;
  logic        last_phase;
  logic        halted;
  logic [15:0] retired_count;

  logic [16:0] mem [64];
  logic        garble = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state (instruction-level view)
  int          m_pc, m_pos, m_cnt;
  logic [16:0] m_ir;
  bit          m_halt;

  fetch_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .curr_instruction (curr_instruction),
    .multicycle_flag  (multicycle_flag),
    .branch_taken     (branch_taken),
    .halt_req         (halt_req),
    .read_select      (read_select),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .exec_phase       (exec_phase),
    .last_phase       (last_phase),
    .halted           (halted),
    .retired_count    (retired_count)
  );

  always #5 clock = ~clock;

  // code memory: registered read, held while run=0
  always @(posedge clock) begin
    if (run) begin
      curr_instruction <= garble ? 17'h0BEEF : mem[read_select];
      multicycle_flag  <= garble ? 1'b0 : mem[read_select][16];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 64; a++) mem[a] = '0;
  endtask

  // reset, then branch from address 0 to target so the next fetch is at target
  task automatic goto_pc(input int target);
    branch_taken = 1'b0;
    halt_req     = 1'b0;
    garble       = 1'b0;
    run          = 1'b1;
    if (target != 0) mem[0] = {9'b0, 8'(target - 1)};
    do_reset();
    if (target != 0) begin
      tick();
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
    end
  endtask

  typedef struct {
    int         start;
    logic [7:0] imm;
    logic       taken;
    logic       halt;
    int         exp_rs;
    logic       exp_halt;
    int         exp_cnt;
  } vec_t;

  vec_t vt[9];

  task automatic model_reset();
    m_pc = 0; m_pos = 0; m_cnt = 0; m_ir = '0; m_halt = 0;
  endtask

  task automatic model_cycle();
    bit          exec, mlast;
    int          mlen, off;
    logic [16:0] exp_instr;
    exec      = !m_halt && (m_pos > 0);
    mlen      = (m_pos == 1) ? (multicycle_flag ? 2 : 1) : 2;
    mlast     = exec && (m_pos == mlen);
    exp_instr = (m_pos == 1) ? curr_instruction : m_ir;
    chk("rnd_read_select", read_select, m_pc);
    chk("rnd_halted", halted, m_halt);
    chk("rnd_exec_phase", exec_phase, exec ? m_pos : 0);
    chk("rnd_instr_valid", instr_valid, exec && run);
    chk("rnd_last_phase", last_phase, mlast && run);
    chk("rnd_retired", retired_count, m_cnt & 16'hFFFF);
    if (exec) chk("rnd_instr", instr, exp_instr);
    if (run && !m_halt) begin
      if (m_pos == 0) begin
        m_pos = 1;
      end else begin
        if (m_pos == 1) m_ir = curr_instruction;
        if (mlast) begin
          m_cnt++;
          if (halt_req) begin
            m_halt = 1;
          end else begin
            off   = branch_taken ? int'($signed(exp_instr[7:0])) : 0;
            m_pc  = (((m_pc + 1 + off) % 64) + 64) % 64;
            m_pos = 0;
          end
        end else begin
          m_pos = 2;
        end
      end
    end
  endtask

  initial begin
    int halt_cycles;

    vt[0] = '{10, 8'hFB, 1'b1, 1'b0,  6, 1'b0, 2};
    vt[1] = '{60, 8'h05, 1'b1, 1'b0,  2, 1'b0, 2};
    vt[2] = '{63, 8'h7F, 1'b0, 1'b0,  0, 1'b0, 2};
    vt[3] = '{ 0, 8'hFF, 1'b1, 1'b0,  0, 1'b0, 1};
    vt[4] = '{20, 8'h03, 1'b1, 1'b1, 20, 1'b1, 2};
    vt[5] = '{33, 8'h80, 1'b1, 1'b0, 34, 1'b0, 2};
    vt[6] = '{ 7, 8'h7F, 1'b1, 1'b0,  7, 1'b0, 2};
    vt[7] = '{12, 8'h10, 1'b0, 1'b0, 13, 1'b0, 2};
    vt[8] = '{45, 8'h00, 1'b0, 1'b1, 45, 1'b1, 2};

    clear_mem();
    #1;
    chk("reset_read_select", read_select, 0);
    chk("reset_instr", instr, 0);
    chk("reset_instr_valid", instr_valid, 0);
    chk("reset_exec_phase", exec_phase, 0);
    chk("reset_last_phase", last_phase, 0);
    chk("reset_halted", halted, 0);
    chk("reset_retired", retired_count, 0);

    // straight-line single-cycle code
    run = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("seq_read_select", read_select, i / 2);
      chk("seq_instr_valid", instr_valid, i % 2);
      tick();
    end
    chk("seq_retired", retired_count, 3);

    // multicycle instruction at 5, garbage on memory output, run stall in EXEC2
    clear_mem();
    goto_pc(5);
    mem[5] = 17'h1_0000;
    chk("mc_fetch_rs", read_select, 5);
    chk("mc_fetch_phase", exec_phase, 0);
    tick();
    chk("mc_e1_phase", exec_phase, 1);
    chk("mc_e1_instr", instr, 17'h1_0000);
    chk("mc_e1_last", last_phase, 0);
    chk("mc_e1_valid", instr_valid, 1);
    garble = 1'b1;
    tick();
    chk("mc_e2_phase", exec_phase, 2);
    chk("mc_e2_instr", instr, 17'h1_0000);
    chk("mc_e2_last", last_phase, 1);
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_valid", instr_valid, 0);
      chk("stall_last", last_phase, 0);
      chk("stall_phase", exec_phase, 2);
      chk("stall_instr", instr, 17'h1_0000);
      chk("stall_rs", read_select, 5);
      chk("stall_retired", retired_count, 1);
    end
    run = 1'b1;
    garble = 1'b0;
    #1;
    chk("resume_valid", instr_valid, 1);
    chk("resume_instr", instr, 17'h1_0000);
    chk("resume_last", last_phase, 1);
    tick();
    chk("mc_next_rs", read_select, 6);
    chk("mc_retired", retired_count, 2);
    chk("mc_next_phase", exec_phase, 0);

    // asynchronous reset in the middle of EXEC2
    clear_mem();
    goto_pc(37);
    mem[37] = 17'h1_0000;
    tick();
    tick();
    chk("ar_pre_phase", exec_phase, 2);
    chk("ar_pre_rs", read_select, 37);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rs", read_select, 0);
    chk("ar_phase", exec_phase, 0);
    chk("ar_retired", retired_count, 0);
    chk("ar_halted", halted, 0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_instr", instr, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // branch / wrap / halt vectors
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      goto_pc(vt[i].start);
      mem[vt[i].start] = {9'b0, vt[i].imm};
      chk("vec_fetch_rs", read_select, vt[i].start);
      tick();
      branch_taken = vt[i].taken;
      halt_req     = vt[i].halt;
      #1;
      chk("vec_last", last_phase, 1);
      chk("vec_instr", instr, {9'b0, vt[i].imm});
      tick();
      branch_taken = 1'b0;
      halt_req     = 1'b0;
      chk("vec_next_rs", read_select, vt[i].exp_rs);
      chk("vec_halted", halted, vt[i].exp_halt);
      chk("vec_retired", retired_count, vt[i].exp_cnt);
      if (vt[i].exp_halt) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("halt_valid", instr_valid, 0);
          chk("halt_stays", halted, 1);
          chk("halt_rs", read_select, vt[i].exp_rs);
          chk("halt_retired", retired_count, vt[i].exp_cnt);
        end
      end
    end

    // randomized run against the reference model
    for (int a = 0; a < 64; a++) mem[a] = {($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, 16'($urandom)};
    garble = 1'b0;
    run = 1'b1;
    branch_taken = 1'b0;
    halt_req = 1'b0;
    do_reset();
    model_reset();
    halt_cycles = 0;
    for (int c = 0; c < 1500; c++) begin
      if (m_halt && halt_cycles > 4) begin
        do_reset();
        model_reset();
        halt_cycles = 0;
      end
      run          = ($urandom_range(0, 9) < 8);
      branch_taken = $urandom_range(0, 1) == 1;
      halt_req     = ($urandom_range(0, 49) == 0);
      #1;
      model_cycle();
      if (m_halt) halt_cycles++;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
